instr_fetch: RTL and testbench

- Thumb-style fetch stage that sits directly upstream of the control-signal generator (CP_GEN).
- Keeps the fetch PC and issues halfword requests to instruction memory over a request/ack handshake.
- Buffers returned instructions in a small prefetch FIFO and presents them to decode with their PC; OPCODE (INSTR[15:6]) drives CP_GEN.
- Handles branch/BX redirects by flushing the FIFO and discarding stale in-flight responses.

---
 rtl/instr_fetch.sv | 98 +++++++++
 tb/tb_instr_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: Thumb-style fetch stage with prefetch FIFO and branch redirect
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   IMEM_REQ/ADDR/ACK             halfword request handshake to instruction memory
//   IMEM_RVALID/RDATA             in-order responses, no backpressure
//   REDIRECT/REDIRECT_PC          taken branch / BX from downstream
//   IF_VALID/IF_INSTR/IF_PC       FIFO head toward decode, OPCODE = IF_INSTR[15:6]
//   ID_READY                      decode accepts the head this cycle
module instr_fetch #(
    parameter int                   PC_WIDTH        = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC        = '0,
    parameter int                   FIFO_DEPTH      = 2,
    parameter int                   MAX_OUTSTANDING = 2
) (
    input  logic                CLK,
    input  logic                RST,
    output logic                IMEM_REQ,
    output logic [PC_WIDTH-1:0] IMEM_ADDR,
    input  logic                IMEM_ACK,
    input  logic                IMEM_RVALID,
    input  logic [15:0]         IMEM_RDATA,
    input  logic                REDIRECT,
    input  logic [PC_WIDTH-1:0] REDIRECT_PC,
    output logic                IF_VALID,
    output logic [15:0]         IF_INSTR,
    output logic [9:0]          OPCODE,
    output logic [PC_WIDTH-1:0] IF_PC,
    input  logic                ID_READY
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [PC_WIDTH-1:0] fpc, rpc, target;
    logic [OW-1:0]       outstanding, drop_cnt;
    logic [CW-1:0]       count;
    logic [AW-1:0]       wptr, rptr;
    logic [15:0]         instr_mem [FIFO_DEPTH];
    logic [PC_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
    logic                accept, resp, keep, pop;

    always_comb begin
        // a response with nothing outstanding is a protocol error and is ignored
        resp      = IMEM_RVALID && (outstanding != '0);
        // credit counts every kept in-flight response as an occupied slot
        IMEM_REQ  = !RST && !REDIRECT && (int'(outstanding) < MAX_OUTSTANDING) &&
                    (int'(outstanding) - int'(drop_cnt) + int'(count) < FIFO_DEPTH);
        IMEM_ADDR = RST ? RESET_PC : fpc;
        accept    = IMEM_REQ && IMEM_ACK;
        keep      = resp && (drop_cnt == '0) && !REDIRECT;
        IF_VALID  = !RST && !REDIRECT && (count != '0);
        pop       = IF_VALID && ID_READY;
        IF_INSTR  = instr_mem[rptr];
        OPCODE    = instr_mem[rptr][15:6];
        IF_PC     = pc_mem[rptr];
        target    = REDIRECT_PC & ~PC_WIDTH'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fpc         <= RESET_PC;
            rpc         <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            wptr        <= '0;
            rptr        <= '0;
        end else begin
            outstanding <= outstanding + OW'(accept) - OW'(resp);
            if (REDIRECT) begin
                // everything still in flight, minus this cycle's response, is stale
                fpc      <= target;
                rpc      <= target;
                drop_cnt <= outstanding - OW'(resp);
                count    <= '0;
                wptr     <= '0;
                rptr     <= '0;
            end else begin
                if (accept) fpc <= fpc + PC_WIDTH'(2);
                if (resp && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
                if (keep) begin
                    rpc  <= rpc + PC_WIDTH'(2);
                    wptr <= wptr + AW'(1);
                end
                if (pop) rptr <= rptr + AW'(1);
                count <= count + CW'(keep) - CW'(pop);
            end
        end
    end

    // write slot is the tail; when full with a pop, it is the slot being vacated
    always_ff @(posedge CLK) begin
        if (keep) begin
            instr_mem[wptr] <= IMEM_RDATA;
            pc_mem[wptr]    <= rpc;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with an in-order memory model
// Ports: none (drives clk, rst, memory responses, redirects and decode ready)
module tb_instr_fetch;
    logic        clk = 0, rst = 1, imem_ack = 1, imem_rvalid = 0, redirect = 0, id_ready = 1;
    logic [15:0] imem_rdata = '0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_pc;
    logic [15:0] if_instr;
    logic [9:0]  opcode;

    typedef struct { logic [31:0] pc; logic [15:0] instr; } ent_t;
    typedef struct { logic [31:0] addr; int due; } req_t;

    ent_t        exp_q[$];
    req_t        pend[$];
    logic [31:0] got_pc[$];
    logic [15:0] got_instr[$];
    logic [31:0] acc_log[$];
    int          n_checks = 0, n_fail = 0, cyc = 0, lat = 1;

    instr_fetch dut (
        .CLK(clk), .RST(rst),
        .IMEM_REQ(imem_req), .IMEM_ADDR(imem_addr), .IMEM_ACK(imem_ack),
        .IMEM_RVALID(imem_rvalid), .IMEM_RDATA(imem_rdata),
        .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
        .IF_VALID(if_valid), .IF_INSTR(if_instr), .OPCODE(opcode), .IF_PC(if_pc),
        .ID_READY(id_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_data(input logic [31:0] a);
        return (a == 32'h0) ? 16'h1C41 : (a == 32'h2) ? 16'h1840 : (a[15:0] ^ 16'hA5C3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // memory model: responds in request order, lat cycles after acceptance
    always @(posedge clk) begin
        #1;
        cyc++;
        imem_rvalid = 0;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1;
            imem_rdata  = mem_data(pend[0].addr);
            pend.delete(0);
        end
    end

    // monitor: records acceptances as expected entries, checks every decode pop
    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            pend.delete();
            exp_q.delete();
        end else begin
            if (if_valid && id_ready) begin
                got_pc.push_back(if_pc);
                got_instr.push_back(if_instr);
                if (exp_q.size() == 0) chk("sb_nonempty", 0, 1);
                else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", if_pc, e.pc);
                    chk("sb_instr", 32'(if_instr), 32'(e.instr));
                    chk("sb_opcode", 32'(opcode), 32'(e.instr[15:6]));
                end
            end
            if (redirect) begin
                chk("redir_if_valid", 32'(if_valid), 0);
                chk("redir_req", 32'(imem_req), 0);
                exp_q.delete();
            end
            if (imem_req && imem_ack) begin
                pend.push_back('{imem_addr, cyc + lat});
                exp_q.push_back('{imem_addr, mem_data(imem_addr)});
                acc_log.push_back(imem_addr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        got_pc.delete();
        got_instr.delete();
        acc_log.delete();
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_if_valid", 32'(if_valid), 0);
        chk("rst_addr", imem_addr, 32'h0);
        tick();
        rst = 0;
        clear_logs();
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1;
        redirect_pc = pc;
        clear_logs();
        tick();
        redirect = 0;
        #1;
    endtask

    task automatic wait_got(input int n);
        int k = 0;
        while (got_pc.size() < n && k < 60) begin
            tick();
            k++;
        end
        chk("wait_got", 32'(got_pc.size() >= n), 1);
    endtask

    task automatic mid_reset(input int pre, input logic full);
        id_ready = 0;
        lat      = 3;
        do_reset();
        repeat (pre) tick();
        chk("mid_pre_req", 32'(imem_req), 0);
        chk("mid_pre_valid", 32'(if_valid), 32'(full));
        do_reset();
        id_ready = 1;
        wait_got(3);
        chk("mid_pc0", got_pc[0], 32'h0);
        chk("mid_pc1", got_pc[1], 32'h2);
        chk("mid_pc2", got_pc[2], 32'h4);
    endtask

    initial begin
        // reset stream
        do_reset();
        #1;
        chk("c0_req", 32'(imem_req), 1);
        chk("c0_addr", imem_addr, 32'h0);
        tick();
        chk("c1_valid", 32'(if_valid), 0);
        tick();
        chk("c2_valid", 32'(if_valid), 1);
        chk("c2_pc", if_pc, 32'h0);
        chk("c2_opcode", 32'(opcode), 32'h071);
        tick();
        chk("c3_pc", if_pc, 32'h2);
        chk("c3_opcode", 32'(opcode), 32'h061);
        repeat (10) tick();
        chk("acc0", acc_log[0], 32'h0);
        chk("acc1", acc_log[1], 32'h2);
        chk("acc2", acc_log[2], 32'h4);
        chk("acc3", acc_log[3], 32'h6);
        chk("got0", got_pc[0], 32'h0);
        chk("got1", got_pc[1], 32'h2);
        chk("got2", got_pc[2], 32'h4);

        // decode stall
        id_ready = 0;
        lat      = 1;
        do_reset();
        repeat (8) tick();
        chk("stall_req", 32'(imem_req), 0);
        chk("stall_acc", 32'(acc_log.size()), 2);
        chk("stall_valid", 32'(if_valid), 1);
        chk("stall_pc", if_pc, 32'h0);
        chk("stall_instr", 32'(if_instr), 32'h1C41);
        id_ready = 1;
        repeat (12) tick();
        chk("stall_got_n", 32'(got_pc.size() >= 3), 1);
        chk("stall_got0", got_pc[0], 32'h0);
        chk("stall_got1", got_pc[1], 32'h2);
        chk("stall_got2", got_pc[2], 32'h4);
        chk("stall_instr2", 32'(got_instr[2]), 32'(mem_data(32'h4)));

        // redirect with 2 outstanding
        lat = 3;
        do_reset();
        tick();
        tick();
        chk("os_limit_req", 32'(imem_req), 0);
        do_redirect(32'h100);
        chk("r100_addr", imem_addr, 32'h100);
        chk("r100_req", 32'(imem_req), 0);
        wait_got(1);
        chk("r100_pc", got_pc[0], 32'h100);
        chk("r100_instr", 32'(got_instr[0]), 32'(mem_data(32'h100)));

        // odd target and address wrap
        lat = 1;
        do_reset();
        repeat (4) tick();
        do_redirect(32'h101);
        chk("odd_addr", imem_addr, 32'h100);
        chk("odd_req", 32'(imem_req), 1);
        repeat (3) tick();
        do_redirect(32'hFFFF_FFFE);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFE);
        repeat (10) tick();
        chk("wrap_acc0", acc_log[0], 32'hFFFF_FFFE);
        chk("wrap_acc1", acc_log[1], 32'h0);
        chk("wrap_got0", got_pc[0], 32'hFFFF_FFFE);
        chk("wrap_got1", got_pc[1], 32'h0);

        // redirect together with a response and a would-be pop
        do_reset();
        tick();
        tick();
        chk("sim_pre_valid", 32'(if_valid), 1);
        do_redirect(32'h200);
        chk("sim_no_pop", 32'(got_pc.size()), 0);
        chk("sim_req", 32'(imem_req), 1);
        chk("sim_addr", imem_addr, 32'h200);
        tick();
        chk("sim_c4_valid", 32'(if_valid), 0);
        tick();
        chk("sim_c5_valid", 32'(if_valid), 1);
        chk("sim_c5_pc", if_pc, 32'h200);
        chk("sim_c5_instr", 32'(if_instr), 32'(mem_data(32'h200)));

        // mid-operation reset: with 2 outstanding, then with the FIFO full
        mid_reset(2, 1'b0);
        mid_reset(6, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
